// File: rtl/iir_inv_if.sv
// Sample handshake bundle for iir_inv: filtered samples in, recovered samples out.
interface iir_inv_if;
   logic               in_valid;
   logic signed [15:0] y_in;
   logic               in_ready;
   logic signed [15:0] x_out;
   logic               out_valid;
   logic               out_ready;

   // master: the side that feeds y_in and drains x_out
   modport master (output in_valid, y_in, out_ready,
                   input  in_ready, x_out, out_valid);
   // slave: the filter inverter itself
   modport slave  (input  in_valid, y_in, out_ready,
                   output in_ready, x_out, out_valid);
endinterface

// File: rtl/iir_inv.sv
// iir_inv: recovers x[n] from y[n] = b1*(x[n]+x[n-1]) + B3*y[n-2].
// One sample at a time through IDLE -> MUL1 -> MUL2 -> HOLD; each
// multiply gets its own cycle and every intermediate result saturates.
module iir_inv #(
   parameter logic signed [15:0] B3        = 16'sd31834, // Q15 feedback on y[n-2]
   parameter logic signed [15:0] KINV      = 16'sd20327, // Q12 reciprocal of b1
   parameter int                 KINV_FRAC = 12
) (
   input  logic      clk,
   input  logic      reset,   // async, active low
   input  logic      flush,
   iir_inv_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MUL1, MUL2, HOLD} state_t;

   state_t             state, state_nxt;
   logic signed [15:0] y_cap;            // sample accepted in IDLE
   logic signed [15:0] y_d1, y_d2, x_d1; // filter history
   logic signed [15:0] t1;               // y[n] - B3*y[n-2], saturated
   logic signed [15:0] x_q;

   logic signed [31:0] fb_prod, k_prod;
   logic signed [16:0] fb_diff;
   logic signed [32:0] x_diff;

   // Clamp a wide signed value into 16 bits; never wrap.
   function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
      if (v > 33'sd32767)       return 16'sh7fff;
      else if (v < -33'sd32768) return 16'sh8000;
      else                      return v[15:0];
   endfunction

   // Full-precision products, then arithmetic (floor) shifts.
   always_comb begin
      fb_prod = 32'(B3) * 32'(y_d2);
      fb_diff = 17'(y_cap) - 17'(fb_prod >>> 15);
      k_prod  = 32'(KINV) * 32'(t1);
      x_diff  = 33'(k_prod >>> KINV_FRAC) - 33'(x_d1);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state; flush overrides every transition.
   always_comb begin
      state_nxt = state;
      if (flush) state_nxt = IDLE;
      else begin
         case (state)
            IDLE: if (bus.in_valid) state_nxt = MUL1;
            MUL1: state_nxt = MUL2;
            MUL2: state_nxt = HOLD;
            HOLD: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == HOLD);
   assign bus.x_out     = x_q;

   // Datapath: capture, two multiply stages, history update with the result.
   // Flush wipes history but leaves the last output visible on x_out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y_cap <= '0;
         y_d1  <= '0;
         y_d2  <= '0;
         x_d1  <= '0;
         t1    <= '0;
         x_q   <= '0;
      end else if (flush) begin
         y_d1  <= '0;
         y_d2  <= '0;
         x_d1  <= '0;
         t1    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) y_cap <= bus.y_in;
            MUL1: t1 <= sat16(33'(fb_diff));
            MUL2: begin
               x_q  <= sat16(x_diff);
               x_d1 <= sat16(x_diff);
               y_d2 <= y_d1;
               y_d1 <= y_cap;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_inv.sv
// Directed bench for iir_inv: reset, impulse, saturation, backpressure,
// flush, reset mid-computation and an 8-sample stream against a model.
module tb_iir_inv;

   localparam longint B3   = 31834;
   localparam longint KINV = 20327;

   logic clk, reset, flush;
   iir_inv_if bus ();

   iir_inv dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));

   int vectors = 0;
   int errs    = 0;
   int cyc     = 0;

   // model history
   longint m_yd1, m_yd2, m_xd1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint msat(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model_clear();
      m_yd1 = 0; m_yd2 = 0; m_xd1 = 0;
   endtask

   task automatic model_step(input longint y, output longint x);
      longint t;
      t = msat(y - ((B3 * m_yd2) >>> 15));
      x = msat(((KINV * t) >>> 12) - m_xd1);
      m_yd2 = m_yd1;
      m_yd1 = y;
      m_xd1 = x;
   endtask

   // Offer one sample from IDLE at a negedge; return at the first negedge
   // with out_valid high (or after a bound) with edges counted.
   task automatic run(input logic signed [15:0] y, output logic signed [15:0] x,
                      output int lat);
      bus.in_valid = 1'b1;
      bus.y_in     = y;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.in_valid = 1'b0;
      end while (!bus.out_valid && lat < 10);
      x = bus.x_out;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.x_out !== 16'sd0) begin
         errs++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b x_out=%0d, want 1 0 0",
                  bus.in_ready, bus.out_valid, bus.x_out);
      end
      reset = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_impulse();
      logic signed [15:0] x; int lat; longint mx;
      run(16'sd3302, x, lat); model_step(3302, mx);
      vectors++;
      if (lat !== 3) begin errs++; $display("FAIL impulse_latency: got %0d edges, want 3", lat); end
      vectors++;
      if (x !== 16'sd16386) begin errs++; $display("FAIL impulse_x0: got %0d, want 16386", x); end
      @(negedge clk);
      run(16'sd0, x, lat); model_step(0, mx);
      vectors++;
      if (x !== -16'sd16386) begin errs++; $display("FAIL impulse_x1: got %0d, want -16386", x); end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_saturation();
      logic signed [15:0] x; int lat; longint mx;
      do_reset();
      run(16'sd32767, x, lat); model_step(32767, mx);
      vectors++;
      if (x !== 16'sd32767) begin errs++; $display("FAIL sat_pos: got %0d, want 32767", x); end
      @(negedge clk);
      do_reset();
      run(-16'sd32768, x, lat); model_step(-32768, mx);
      vectors++;
      if (x !== -16'sd32768) begin errs++; $display("FAIL sat_neg: got %0d, want -32768", x); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic signed [15:0] x; int lat; longint mx;
      bus.out_ready = 1'b0;
      run(16'sd1200, x, lat); model_step(1200, mx);
      vectors++;
      if (x !== 16'(mx)) begin errs++; $display("FAIL bp_first: got %0d, want %0d", x, mx); end
      bus.in_valid = 1'b1;
      bus.y_in     = 16'sd7777;   // must not be taken while holding
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         vectors++;
         if (bus.x_out !== x || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_hold[%0d]: x_out=%0d out_valid=%b in_ready=%b, want %0d 1 0",
                     i, bus.x_out, bus.out_valid, bus.in_ready, x);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errs++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
      end
      // next result only matches if 7777 was never consumed
      run(-16'sd900, x, lat); model_step(-900, mx);
      vectors++;
      if (x !== 16'(mx)) begin errs++; $display("FAIL bp_next: got %0d, want %0d", x, mx); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      logic signed [15:0] x, xprev; int lat; longint mx;
      xprev = bus.x_out;
      bus.in_valid = 1'b1; bus.y_in = 16'sd4000;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);   // now in MUL2
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      model_clear();
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.x_out !== xprev) begin
         errs++;
         $display("FAIL flush_state: in_ready=%b out_valid=%b x_out=%0d, want 1 0 %0d",
                  bus.in_ready, bus.out_valid, bus.x_out, xprev);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         vectors++;
         if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL flush_quiet[%0d]: out_valid=%b, want 0", i, bus.out_valid); end
      end
      run(16'sd3302, x, lat); model_step(3302, mx);
      vectors++;
      if (x !== 16'sd16386) begin errs++; $display("FAIL flush_after: got %0d, want 16386", x); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bus.in_valid = 1'b1; bus.y_in = 16'sd5000;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);                  // MUL2
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.x_out !== 16'sd0 || bus.in_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_mid: out_valid=%b x_out=%0d in_ready=%b, want 0 0 1",
                  bus.out_valid, bus.x_out, bus.in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic signed [15:0] vec [8];
      logic signed [15:0] x; int lat, prev; longint mx;
      vec = '{16'sd1000, -16'sd2000, 16'sd3302, 16'sd0,
              16'sd12000, -16'sd15000, 16'sd32767, -16'sd32768};
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         run(vec[i], x, lat); model_step(vec[i], mx);
         vectors++;
         if (x !== 16'(mx)) begin errs++; $display("FAIL stream_x[%0d]: got %0d, want %0d", i, x, mx); end
         if (i > 0) begin
            vectors++;
            if (cyc - prev !== 4) begin errs++; $display("FAIL stream_period[%0d]: got %0d cycles, want 4", i, cyc - prev); end
         end
         prev = cyc;
         @(posedge clk); @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.y_in = '0; bus.out_ready = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      test_reset();
      test_impulse();
      test_saturation();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/iir_inv.md
IIR_INV -- requirements
Module: iir_inv

Interface
REQ-001 Parameter B3, default 31834: feedback coefficient, signed Q15, applied to y[n-2].
REQ-002 Parameter KINV, default 20327: reciprocal of forward gain b1 (6603 Q15), signed Q12.
REQ-003 Parameter KINV_FRAC, default 12: fractional bits of KINV, used as arithmetic right-shift count.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of filter history and pipeline.
REQ-007 in_valid  input  1  y_in holds a valid filtered sample.
REQ-008 y_in  input  16  filtered sample y[n], signed two's complement.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 x_out  output  16  recovered sample x[n], signed, registered.
REQ-011 out_valid  output  1  x_out holds a valid result.
REQ-012 out_ready  input  1  downstream accepts x_out this cycle.

Function
REQ-013 The block SHALL invert y[n] = b1*(x[n]+x[n-1]) + B3*y[n-2], computing x[n] = KINV*(y[n] - B3*y[n-2]) - x[n-1].
REQ-014 FSM states SHALL be IDLE, MUL1, MUL2, HOLD; in_ready = 1 only in IDLE; out_valid = 1 only in HOLD.
REQ-015 IDLE -> MUL1 on in_valid & in_ready; y_in SHALL be captured on that edge (acceptance edge).
REQ-016 MUL1 -> MUL2 unconditionally; that edge SHALL register t1 = sat16(y_in - ((B3*y_d2) >>> 15)), product 32-bit signed, difference 17-bit signed.
REQ-017 MUL2 -> HOLD unconditionally; that edge SHALL register x_out = sat16(((KINV*t1) >>> KINV_FRAC) - x_d1), product 32-bit signed, arithmetic (floor) shift.
REQ-018 sat16 SHALL clamp to [-32768, 32767]; no wrap-around anywhere.
REQ-019 On the MUL2 -> HOLD edge history SHALL update: y_d2 <= y_d1, y_d1 <= captured y_in, x_d1 <= new x_out value.
REQ-020 Latency: out_valid SHALL rise on the 3rd rising edge counting the acceptance edge as the 1st.
REQ-021 HOLD -> IDLE on out_valid & out_ready; x_out SHALL hold its value until overwritten by the next MUL2 -> HOLD edge.
REQ-022 In HOLD with out_ready = 0, x_out and out_valid SHALL remain stable indefinitely and no new input SHALL be accepted.
REQ-023 Maximum throughput SHALL be one sample per 4 cycles; no acceptance in the same cycle as an output transfer.
REQ-024 flush = 1 SHALL, on the next edge, force IDLE, clear y_d1, y_d2, x_d1, t1 and out_valid, abandon any in-flight sample, and hold x_out unchanged; flush takes priority over all transitions.
REQ-025 Coefficients SHALL be used as signed 16-bit values; products SHALL be full-precision before shifting.

Reset
REQ-026 reset = 0 SHALL asynchronously force IDLE, x_out = 0, out_valid = 0, in_ready = 1, and y_d1 = y_d2 = x_d1 = t1 = 0.
REQ-027 After reset deasserts, the first rising edge with in_valid = 1 SHALL be a valid acceptance edge.

Verification
REQ-028 Reset: assert reset mid-MUL2 -> out_valid = 0, x_out = 0, in_ready = 1 immediately without a clock edge.
REQ-029 Impulse: zero history, y_in = 3302 -> x_out = 16386 with out_valid high on the 3rd edge; then y_in = 0 -> x_out = -16386.
REQ-030 Saturation: zero history, y_in = 32767 -> x_out = 32767; after reset, y_in = -32768 -> x_out = -32768.
REQ-031 Backpressure: out_ready = 0 for 5 cycles in HOLD with in_valid = 1 -> x_out and out_valid stable, in_ready = 0, no sample consumed; out_ready = 1 -> IDLE on the next edge.
REQ-032 Flush: flush = 1 during MUL2 -> IDLE, out_valid stays 0, no output; next y_in = 3302 -> x_out = 16386, confirming cleared history.
REQ-033 Streaming: 8 back-to-back samples with out_ready = 1 -> one output per 4 cycles, matching a bit-accurate model of REQ-016..019.
